rom_port_arbiter: RTL and testbench

//  Shares the single-port instruction ROM among three requesters:
//    - the fetch unit (PC address in, instruction out);
//    - the data-memory load/store port, for constant-pool reads from ROM space;
//    - the UART program downloader.

---
 rtl/rom_port_arbiter_pkg.sv | 20 ++
 rtl/rom_port_arbiter.sv | 109 ++++++++++
 tb/tb_rom_port_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_port_arbiter_pkg.sv
// Shared constants for the ROM port arbiter: front-end hold codes, the default
// ROM address width and the arbiter FSM state encoding.
package rom_port_arbiter_pkg;

    localparam int ROM_ADDR_W = 12;

    localparam logic [2:0] HOLD_NONE = 3'b000;
    localparam logic [2:0] HOLD_PC   = 3'b001;
    localparam logic [2:0] HOLD_IF   = 3'b010;
    localparam logic [2:0] HOLD_ID   = 3'b011;

    typedef enum logic [2:0] {
        ST_FETCH   = 3'd0,
        ST_DM_ACC  = 3'd1,
        ST_DM_RESP = 3'd2,
        ST_DL      = 3'd3,
        ST_DL_EXIT = 3'd4
    } arb_state_e;

endpackage

// File: rtl/rom_port_arbiter.sv
// Single-port instruction ROM shared by fetch, LSU constant-pool accesses and the
// UART downloader. Fetch owns the port by default; priority is dl > dm > fetch.
module rom_port_arbiter
    import rom_port_arbiter_pkg::*;
#(
    parameter int          ADDR_W         = ROM_ADDR_W,
    parameter logic [31:0] RESET_VECTOR   = 32'h0,
    parameter bit          ALLOW_DM_WRITE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       if_addr_i,
    output logic [31:0]       if_ins_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [31:0]       dm_addr_i,
    input  logic [31:0]       dm_wdata_i,
    output logic              dm_ack_o,
    output logic [31:0]       dm_rdata_o,
    input  logic              dl_req_i,
    input  logic [ADDR_W-1:0] dl_addr_i,
    input  logic [31:0]       dl_wdata_i,
    output logic              dl_ack_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    output logic              rom_we_o,
    output logic [31:0]       rom_wdata_o,
    input  logic [31:0]       rom_rdata_i,
    output logic [2:0]        hold_o,
    output logic              jump_flag_o,
    output logic [31:0]       jump_addr_o
);

    arb_state_e  state, state_nxt;
    logic        dm_we_q;
    logic [31:0] rdata_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_FETCH;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH:   if (dl_req_i) state_nxt = ST_DL;
                        else if (dm_req_i) state_nxt = ST_DM_ACC;
            ST_DM_ACC:  state_nxt = ST_DM_RESP;
            ST_DM_RESP: state_nxt = dl_req_i ? ST_DL : ST_FETCH;
            ST_DL:      if (!dl_req_i) state_nxt = ST_DL_EXIT;
            ST_DL_EXIT: state_nxt = ST_FETCH;
            default:    state_nxt = ST_FETCH;
        endcase
    end

    // Address/write mux. In DL the closing cycle (dl_req_i already low) must not
    // write, so the downloader strobes are qualified by dl_req_i.
    always_comb begin
        rom_addr_o  = if_addr_i[ADDR_W+1:2];
        rom_we_o    = 1'b0;
        rom_wdata_o = '0;
        case (state)
            ST_DM_ACC: begin
                rom_addr_o  = dm_addr_i[ADDR_W+1:2];
                rom_we_o    = dm_we_i & ALLOW_DM_WRITE;
                rom_wdata_o = dm_wdata_i;
            end
            ST_DL: begin
                rom_addr_o  = dl_addr_i;
                rom_we_o    = dl_req_i;
                rom_wdata_o = dl_wdata_i;
            end
            ST_DL_EXIT: rom_addr_o = RESET_VECTOR[ADDR_W+1:2];
            default: ;
        endcase
    end

    always_comb begin
        case (state)
            ST_DM_ACC, ST_DM_RESP: hold_o = HOLD_IF;
            ST_DL, ST_DL_EXIT:     hold_o = HOLD_ID;
            default:               hold_o = HOLD_NONE;
        endcase
    end

    assign dm_ack_o    = (state == ST_DM_RESP);
    assign dl_ack_o    = (state == ST_DL) & dl_req_i;
    assign jump_flag_o = (state == ST_DL_EXIT);
    assign jump_addr_o = jump_flag_o ? RESET_VECTOR : 32'h0;
    assign if_ins_o    = rom_rdata_i;

    // The read word arrives from the ROM register during the ack cycle; it is
    // passed through then and held in rdata_q until the next read ack.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_we_q <= 1'b0;
            rdata_q <= '0;
        end else begin
            if (state == ST_DM_ACC) dm_we_q <= dm_we_i;
            if (state == ST_DM_RESP && !dm_we_q) rdata_q <= rom_rdata_i;
        end
    end

    assign dm_rdata_o = (state == ST_DM_RESP && !dm_we_q) ? rom_rdata_i : rdata_q;

    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr_i[31:ADDR_W+2], if_addr_i[1:0],
                                dm_addr_i[31:ADDR_W+2], dm_addr_i[1:0]};

endmodule

// File: tb/tb_rom_port_arbiter.sv
// Directed bench: two arbiters (dm writes allowed / dropped) driven in lockstep,
// each with its own synchronous ROM model.
module tb_rom_port_arbiter;
    import rom_port_arbiter_pkg::*;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [31:0]   if_addr, dm_addr, dm_wdata, dl_wdata;
    logic          dm_req, dm_we, dl_req;
    logic [AW-1:0] dl_addr;

    logic [31:0]   if_ins_a, dm_rdata_a, rom_wdata_a, rom_rdata_a, jump_addr_a;
    logic          dm_ack_a, dl_ack_a, rom_we_a, jump_a;
    logic [AW-1:0] rom_addr_a;
    logic [2:0]    hold_a;

    logic [31:0]   if_ins_b, dm_rdata_b, rom_wdata_b, rom_rdata_b, jump_addr_b;
    logic          dm_ack_b, dl_ack_b, rom_we_b, jump_b;
    logic [AW-1:0] rom_addr_b;
    logic [2:0]    hold_b;

    logic [31:0] rom_a [0:(1<<AW)-1];
    logic [31:0] rom_b [0:(1<<AW)-1];
    bit init_a = 1'b0;
    bit init_b = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.ADDR_W(AW), .RESET_VECTOR(32'h0), .ALLOW_DM_WRITE(1'b1)) dut_a (
        .clk(clk), .rst_n(rst_n), .if_addr_i(if_addr), .if_ins_o(if_ins_a),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack_a), .dm_rdata_o(dm_rdata_a),
        .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_wdata_i(dl_wdata), .dl_ack_o(dl_ack_a),
        .rom_addr_o(rom_addr_a), .rom_we_o(rom_we_a), .rom_wdata_o(rom_wdata_a),
        .rom_rdata_i(rom_rdata_a), .hold_o(hold_a),
        .jump_flag_o(jump_a), .jump_addr_o(jump_addr_a));

    rom_port_arbiter #(.ADDR_W(AW), .RESET_VECTOR(32'h0), .ALLOW_DM_WRITE(1'b0)) dut_b (
        .clk(clk), .rst_n(rst_n), .if_addr_i(if_addr), .if_ins_o(if_ins_b),
        .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr), .dm_wdata_i(dm_wdata),
        .dm_ack_o(dm_ack_b), .dm_rdata_o(dm_rdata_b),
        .dl_req_i(dl_req), .dl_addr_i(dl_addr), .dl_wdata_i(dl_wdata), .dl_ack_o(dl_ack_b),
        .rom_addr_o(rom_addr_b), .rom_we_o(rom_we_b), .rom_wdata_o(rom_wdata_b),
        .rom_rdata_i(rom_rdata_b), .hold_o(hold_b),
        .jump_flag_o(jump_b), .jump_addr_o(jump_addr_b));

    // ROM models: word i preloaded with i, except word 0x10.
    always @(posedge clk) begin
        if (!init_a) begin
            for (int i = 0; i < (1<<AW); i++) rom_a[i] = i;
            rom_a[16] = 32'hDEADBEEF;
            init_a = 1'b1;
        end else begin
            rom_rdata_a <= rom_a[rom_addr_a];
            if (rom_we_a) rom_a[rom_addr_a] <= rom_wdata_a;
        end
    end

    always @(posedge clk) begin
        if (!init_b) begin
            for (int i = 0; i < (1<<AW); i++) rom_b[i] = i;
            rom_b[16] = 32'hDEADBEEF;
            init_b = 1'b1;
        end else begin
            rom_rdata_b <= rom_b[rom_addr_b];
            if (rom_we_b) rom_b[rom_addr_b] <= rom_wdata_b;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; if_addr = 32'h100;
        dm_req = 0; dm_we = 0; dm_addr = 0; dm_wdata = 0;
        dl_req = 0; dl_addr = 0; dl_wdata = 0;

        // 1. reset values, then reset pulse while in DL
        repeat (2) cyc();
        #2;
        chk("rst_hold", hold_a, HOLD_NONE);
        chk("rst_dm_ack", dm_ack_a, 0);
        chk("rst_dl_ack", dl_ack_a, 0);
        chk("rst_we", rom_we_a, 0);
        chk("rst_jump", jump_a, 0);
        chk("rst_rdata", dm_rdata_a, 0);
        cyc(); rst_n = 1'b1;
        cyc(); dl_req = 1; dl_addr = 12'h100; dl_wdata = 32'h55;
        cyc(); #2;
        chk("dl_enter_hold", hold_a, HOLD_ID);
        chk("dl_enter_ack", dl_ack_a, 1);
        rst_n = 1'b0; #1;
        chk("midrst_hold", hold_a, HOLD_NONE);
        chk("midrst_dl_ack", dl_ack_a, 0);
        chk("midrst_we", rom_we_a, 0);
        chk("midrst_jump", jump_a, 0);
        cyc(); rst_n = 1'b1; dl_req = 0; #2;
        chk("postrst_hold", hold_a, HOLD_NONE);
        chk("postrst_jump", jump_a, 0);
        cyc(); #2;
        chk("postrst_jump2", jump_a, 0);
        chk("postrst_hold2", hold_a, HOLD_NONE);

        // 2. idle fetch
        for (int i = 0; i < 20; i++) begin
            cyc(); if_addr = 32'h200 + 4*i; #2;
            chk("idle_addr", rom_addr_a, 12'h80 + i);
            chk("idle_hold", hold_a, HOLD_NONE);
            chk("idle_acks", {dm_ack_a, dl_ack_a, jump_a}, 0);
            if (i > 0) chk("idle_ins", if_ins_a, 32'h80 + i - 1);
        end

        // 3. dm read of byte 0x40 -> word 0x10
        cyc(); if_addr = 32'h300; dm_req = 1; dm_we = 0; dm_addr = 32'h40; #2;
        chk("rd_fetch_addr", rom_addr_a, 12'hC0);
        chk("rd_fetch_hold", hold_a, HOLD_NONE);
        cyc(); #2;
        chk("rd_acc_hold", hold_a, HOLD_IF);
        chk("rd_acc_addr", rom_addr_a, 12'h10);
        chk("rd_acc_we", rom_we_a, 0);
        chk("rd_acc_ack", dm_ack_a, 0);
        cyc(); #2;
        chk("rd_resp_hold", hold_a, HOLD_IF);
        chk("rd_resp_ack", dm_ack_a, 1);
        chk("rd_resp_data", dm_rdata_a, 32'hDEADBEEF);
        chk("rd_resp_addr", rom_addr_a, 12'hC0);
        dm_req = 0;
        cyc(); #2;
        chk("rd_back_hold", hold_a, HOLD_NONE);
        chk("rd_back_ack", dm_ack_a, 0);
        chk("rd_held_data", dm_rdata_a, 32'hDEADBEEF);
        chk("rd_back_ins", if_ins_a, 32'hC0);

        // 4. dm write to 0x44, held request -> one fetch cycle between accesses
        cyc(); dm_req = 1; dm_we = 1; dm_addr = 32'h44; dm_wdata = 32'h12345678; #2;
        cyc(); #2;
        chk("wr_we_allow", rom_we_a, 1);
        chk("wr_we_drop", rom_we_b, 0);
        chk("wr_wdata", rom_wdata_a, 32'h12345678);
        cyc(); #2;
        chk("wr_ack_a", dm_ack_a, 1);
        chk("wr_ack_b", dm_ack_b, 1);
        chk("wr_resp_we", rom_we_a, 0);
        chk("wr_rdata_kept", dm_rdata_a, 32'hDEADBEEF);
        cyc(); #2;
        chk("b2b_fetch_hold", hold_a, HOLD_NONE);
        chk("b2b_fetch_ack", dm_ack_a, 0);
        cyc(); #2;
        chk("b2b_acc_hold", hold_a, HOLD_IF);
        cyc(); #2;
        chk("b2b_ack", dm_ack_a, 1);
        dm_req = 0; dm_we = 0;
        cyc(); #2;
        chk("wr_rom_a", rom_a[17], 32'h12345678);
        chk("wr_rom_b", rom_b[17], 32'h11);

        // 5. download 4 words with a dm read of word 2 pending
        cyc(); dl_req = 1; dl_addr = 0; dl_wdata = 32'hA0;
        dm_req = 1; dm_we = 0; dm_addr = 32'h8; #2;
        chk("dl_fetch_ack", dl_ack_a, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(); dl_addr = i; dl_wdata = 32'hA0 + i; #2;
            chk("dl_ack", dl_ack_a, 1);
            chk("dl_we", rom_we_a, 1);
            chk("dl_addr", rom_addr_a, i);
            chk("dl_hold", hold_a, HOLD_ID);
            chk("dl_dm_wait", dm_ack_a, 0);
        end
        cyc(); dl_req = 0; #2;
        chk("dl_end_ack", dl_ack_a, 0);
        chk("dl_end_we", rom_we_a, 0);
        chk("dl_end_hold", hold_a, HOLD_ID);
        cyc(); #2;
        chk("dlx_jump", jump_a, 1);
        chk("dlx_jaddr", jump_addr_a, 32'h0);
        chk("dlx_addr", rom_addr_a, 0);
        chk("dlx_hold", hold_a, HOLD_ID);
        chk("dlx_dm_ack", dm_ack_a, 0);
        cyc(); #2;
        chk("dlf_hold", hold_a, HOLD_NONE);
        chk("dlf_jump", jump_a, 0);
        chk("dlf_dm_ack", dm_ack_a, 0);
        cyc(); #2;
        chk("dlm_acc_hold", hold_a, HOLD_IF);
        cyc(); #2;
        chk("dlm_ack", dm_ack_a, 1);
        chk("dlm_data", dm_rdata_a, 32'hA2);
        dm_req = 0;
        for (int i = 0; i < 4; i++) chk("dl_rom", rom_a[i], 32'hA0 + i);
        chk("dl_rom_keep", rom_a[16], 32'hDEADBEEF);

        // 6. dl raised during DM_ACC
        cyc(); dm_req = 1; dm_we = 0; dm_addr = 32'h0; #2;
        cyc(); dl_req = 1; dl_addr = 12'h20; dl_wdata = 32'hBB; #2;
        chk("pre_acc_hold", hold_a, HOLD_IF);
        chk("pre_acc_dl_ack", dl_ack_a, 0);
        cyc(); #2;
        chk("pre_resp_ack", dm_ack_a, 1);
        chk("pre_resp_data", dm_rdata_a, 32'hA0);
        chk("pre_resp_dl_ack", dl_ack_a, 0);
        dm_req = 0;
        cyc(); #2;
        chk("pre_dl_hold", hold_a, HOLD_ID);
        chk("pre_dl_ack", dl_ack_a, 1);
        cyc(); dl_req = 0; #2;
        chk("pre_dl_end", dl_ack_a, 0);
        cyc(); #2;
        chk("pre_dlx_jump", jump_a, 1);
        cyc(); #2;
        chk("pre_fetch_hold", hold_a, HOLD_NONE);
        chk("pre_rom", rom_a[32], 32'hBB);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
